// File: rtl/aos_cfg_fifo.sv
// Parametrised buffer FIFO: selectable FWFT or registered read, any depth >= 2, status flags, sticky errors.
// Latency: enqueue visible at the head 1 cycle after the write edge; registered-read data 1 cycle after deq_en.
// Backpressure: enq_en while full is dropped (overflow), deq_en while empty is ignored (underflow); both are sticky.
// Ports: clk/rst (sync, active-high); enq_en/enq_data in, full/almost_full out; deq_en in,
//        deq_data/deq_valid/empty/almost_empty out; count = array occupancy; overflow/underflow sticky, clear_err clears.
module aos_cfg_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 2,
  parameter int FIFO_TYPE = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_en,
  input  logic [WIDTH-1:0] enq_data,
  output logic             full,
  output logic             almost_full,
  input  logic             deq_en,
  output logic [WIDTH-1:0] deq_data,
  output logic             deq_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          enq_acc, deq_acc;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths never walk off the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status is a pure decode of the registered occupancy.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses the pre-edge state only: a same-cycle dequeue never frees
  // room for an enqueue, and a same-cycle enqueue never feeds a dequeue.
  assign enq_acc = enq_en && !full;
  assign deq_acc = deq_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (enq_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_acc) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (enq_acc && !deq_acc)      count_d = count_q + CW'(1);
    else if (deq_acc && !enq_acc) count_d = count_q - CW'(1);

    // A new error event in the same cycle as clear_err leaves the flag set.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (enq_en && full)  overflow_d  = 1'b1;
    if (deq_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; writes are suppressed in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && enq_acc) mem[wr_ptr_q] <= enq_data;
  end

  if (FIFO_TYPE == 0) begin : g_fwft
    assign deq_data  = mem[rd_ptr_q];
    assign deq_valid = !empty;
  end else if (FIFO_TYPE == 1) begin : g_reg
    logic [WIDTH-1:0] deq_data_q, deq_data_d;
    logic             deq_valid_q, deq_valid_d;

    // Output register holds its last value between reads; valid is a one-cycle pulse per read.
    always_comb begin
      deq_data_d  = deq_data_q;
      deq_valid_d = deq_acc;
      if (deq_acc) deq_data_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        deq_data_q  <= '0;
        deq_valid_q <= 1'b0;
      end else begin
        deq_data_q  <= deq_data_d;
        deq_valid_q <= deq_valid_d;
      end
    end

    assign deq_data  = deq_data_q;
    assign deq_valid = deq_valid_q;
  end else begin : g_bad_type
    $error("aos_cfg_fifo: FIFO_TYPE must be 0 (FWFT) or 1 (registered read)");
    assign deq_data  = '0;
    assign deq_valid = 1'b0;
  end

endmodule

// File: tb/tb_aos_cfg_fifo.sv
// Three FIFO configurations driven by one shared stimulus stream:
//   inst 0: DEPTH=3, FWFT, AF=2 (default), AE=1
//   inst 1: DEPTH=5, FWFT, AF=4, AE=1
//   inst 2: DEPTH=4, registered read, AF=4, AE=0
module tb_aos_cfg_fifo;

  logic       clk;
  logic       rst;
  logic       enq_en;
  logic [7:0] enq_data;
  logic       deq_en;
  logic       clear_err;

  logic [2:0] full_v, afull_v, empty_v, aempty_v, dval_v, ovf_v, udf_v;
  logic [7:0] ddat0, ddat1, ddat2;
  logic [1:0] cnt0;
  logic [2:0] cnt1, cnt2;

  int tests;
  int fails;
  bit started;

  aos_cfg_fifo #(.WIDTH(8), .DEPTH(3), .FIFO_TYPE(0)) u_f0 (
    .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data),
    .full(full_v[0]), .almost_full(afull_v[0]), .deq_en(deq_en),
    .deq_data(ddat0), .deq_valid(dval_v[0]), .empty(empty_v[0]),
    .almost_empty(aempty_v[0]), .count(cnt0), .overflow(ovf_v[0]),
    .underflow(udf_v[0]), .clear_err(clear_err));

  aos_cfg_fifo #(.WIDTH(8), .DEPTH(5), .FIFO_TYPE(0), .AF_THRESH(4), .AE_THRESH(1)) u_f1 (
    .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data),
    .full(full_v[1]), .almost_full(afull_v[1]), .deq_en(deq_en),
    .deq_data(ddat1), .deq_valid(dval_v[1]), .empty(empty_v[1]),
    .almost_empty(aempty_v[1]), .count(cnt1), .overflow(ovf_v[1]),
    .underflow(udf_v[1]), .clear_err(clear_err));

  aos_cfg_fifo #(.WIDTH(8), .DEPTH(4), .FIFO_TYPE(1), .AF_THRESH(4), .AE_THRESH(0)) u_f2 (
    .clk(clk), .rst(rst), .enq_en(enq_en), .enq_data(enq_data),
    .full(full_v[2]), .almost_full(afull_v[2]), .deq_en(deq_en),
    .deq_data(ddat2), .deq_valid(dval_v[2]), .empty(empty_v[2]),
    .almost_empty(aempty_v[2]), .count(cnt2), .overflow(ovf_v[2]),
    .underflow(udf_v[2]), .clear_err(clear_err));

  function automatic int cfg_depth(input int i);
    return (i == 0) ? 3 : (i == 1) ? 5 : 4;
  endfunction
  function automatic int cfg_af(input int i);
    return (i == 0) ? 2 : 4;
  endfunction
  function automatic int cfg_ae(input int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic bit cfg_reg(input int i);
    return (i == 2);
  endfunction

  // Reference model: per instance, an ordered list where element 0 is the oldest
  // entry (the scoreboard of expected read data), plus the sticky flags and the
  // expected registered-read output.
  logic [7:0] mq   [3][8];
  int         msz  [3];
  bit         movf [3];
  bit         mudf [3];
  bit         mrv  [3];
  logic [7:0] mrd  [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model update on every active edge, from the inputs held across that edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        int  d;
        bit  acc_e, acc_d;
        d = cfg_depth(i);
        if (rst) begin
          msz[i]  = 0;
          movf[i] = 1'b0;
          mudf[i] = 1'b0;
          mrv[i]  = 1'b0;
          mrd[i]  = 8'h00;
        end else begin
          acc_e = enq_en && (msz[i] < d);
          acc_d = deq_en && (msz[i] > 0);
          movf[i] = (movf[i] && !clear_err) || (enq_en && msz[i] == d);
          mudf[i] = (mudf[i] && !clear_err) || (deq_en && msz[i] == 0);
          if (cfg_reg(i)) begin
            mrv[i] = acc_d;
            if (acc_d) mrd[i] = mq[i][0];
          end
          if (acc_d) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            msz[i] = msz[i] - 1;
          end
          if (acc_e) begin
            mq[i][msz[i]] = enq_data;
            msz[i] = msz[i] + 1;
          end
        end
      end
      if (rst) started = 1'b1;
    end
  end

  task automatic chk(input string name, input int i, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h expected 0x%0h", name, i, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic f, input logic af, input logic e,
                            input logic ae, input logic dv, input logic ov, input logic un,
                            input logic [7:0] dd, input int cnt);
    int n;
    n = msz[i];
    chk("count", i, cnt, n);
    chk("full", i, int'(f), int'(n == cfg_depth(i)));
    chk("empty", i, int'(e), int'(n == 0));
    chk("almost_full", i, int'(af), int'(n >= cfg_af(i)));
    chk("almost_empty", i, int'(ae), int'(n <= cfg_ae(i)));
    chk("overflow", i, int'(ov), int'(movf[i]));
    chk("underflow", i, int'(un), int'(mudf[i]));
    if (cfg_reg(i)) begin
      chk("deq_valid", i, int'(dv), int'(mrv[i]));
      chk("deq_data", i, int'(dd), int'(mrd[i]));
    end else begin
      chk("deq_valid", i, int'(dv), int'(n > 0));
      if (dv && n > 0) chk("deq_data", i, int'(dd), int'(mq[i][0]));
    end
  endtask

  // Monitor: compares every instance against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check_inst(0, full_v[0], afull_v[0], empty_v[0], aempty_v[0], dval_v[0], ovf_v[0], udf_v[0], ddat0, int'(cnt0));
        check_inst(1, full_v[1], afull_v[1], empty_v[1], aempty_v[1], dval_v[1], ovf_v[1], udf_v[1], ddat1, int'(cnt1));
        check_inst(2, full_v[2], afull_v[2], empty_v[2], aempty_v[2], dval_v[2], ovf_v[2], udf_v[2], ddat2, int'(cnt2));
      end
    end
  end

  task automatic step(input bit e, input logic [7:0] d, input bit de, input bit c, input bit r);
    enq_en    = e;
    enq_data  = d;
    deq_en    = de;
    clear_err = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    started = 1'b0;
    for (int i = 0; i < 3; i++) begin
      msz[i] = 0; movf[i] = 1'b0; mudf[i] = 1'b0; mrv[i] = 1'b0; mrd[i] = 8'h00;
    end

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // Fill with three values, drain through the pointer wrap.
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Full with simultaneous enqueue and dequeue, then clear the error.
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Single write and read pulse, then hold.
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Empty: dequeue alongside enqueue must not bypass.
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h5A, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Walk occupancy 0 -> 5 past every threshold, plus overflow on the shallow ones.
    for (int k = 0; k < 6; k++) step(1, 8'(8'hC0 + k), 0, 0, 0);

    // Reset mid-operation with an enqueue pending.
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hEE, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h77, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Randomized phases: fill-biased, drain-biased, balanced.
    for (int n = 0; n < 1800; n++) begin
      int mode;
      bit e, de, c, r;
      mode = (n / 60) % 3;
      case (mode)
        0:       begin e = ($urandom_range(0, 9) < 8); de = ($urandom_range(0, 9) < 2); end
        1:       begin e = ($urandom_range(0, 9) < 2); de = ($urandom_range(0, 9) < 8); end
        default: begin e = $urandom_range(0, 1) == 1;  de = $urandom_range(0, 1) == 1;  end
      endcase
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 149) == 0);
      step(e, 8'($urandom_range(0, 255)), de, c, r);
    end

    step(0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    if (tests == 0) begin
      fails++;
      $display("FAIL no_checks: got 0 comparisons, required > 0");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aos_cfg_fifo.md
Name: aos_cfg_fifo

Overview:
Generic, parametrised buffer FIFO used wherever a *_FIFO_Type / *_FIFO_Depth pair is configured, e.g. the AXIL soft-reg paths, the AMI-to-AXI4 read/write paths and the PCIS paths. It replaces fixed-depth, fixed-mode buffers with one block that has the following features:
- selectable read mode (first-word-fall-through or registered output);
- arbitrary depth, including non-power-of-two depths;
- programmable almost-full and almost-empty thresholds;
- occupancy count;
- sticky overflow and underflow error flags.

Parameters:
WIDTH, 64, data width in bits (>=1)
DEPTH, 2, number of entries (>=2, not required to be a power of two)
FIFO_TYPE, 0, 0 = FWFT read, 1 = registered read; any other value is an elaboration error
AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
CW, $clog2(DEPTH+1), derived width of count

Ports:
clk  in  1  single clock; all logic is posedge
rst  in  1  synchronous, active-high reset
enq_en  in  1  enqueue request
enq_data  in  WIDTH  data to enqueue
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
deq_en  in  1  dequeue request
deq_data  out  WIDTH  head data (FWFT) or registered read data (type 1)
deq_valid  out  1  deq_data is valid
empty  out  1  count == 0
almost_empty  out  1  count <= AE_THRESH
count  out  CW  current occupancy of the storage array
overflow  out  1  sticky: enq_en seen while full
underflow  out  1  sticky: deq_en seen while empty
clear_err  in  1  clears overflow and underflow

Behaviour:
- Storage:
  - DEPTH x WIDTH array with wr_ptr and rd_ptr, each 0..DEPTH-1.
  - A pointer at DEPTH-1 wraps to 0 on increment; power-of-two overflow is never relied on.
- Accepted operations:
  - Enqueue is accepted iff enq_en && !full: write mem[wr_ptr], then advance wr_ptr.
  - Dequeue is accepted iff deq_en && !empty: advance rd_ptr.
  - full and empty are evaluated on the pre-edge count.
- Count update:
  - count increments on accept-enq only, decrements on accept-deq only, and is unchanged when both are accepted.
  - count is registered.
  - full, empty, almost_full and almost_empty are combinational decodes of count.
- Simultaneous requests at the boundaries:
  - When full, enq_en is rejected even if deq_en is accepted in the same cycle.
  - When empty, deq_en is rejected even if enq_en is accepted; data never bypasses the array.
- FIFO_TYPE 0 (FWFT):
  - deq_data = mem[rd_ptr] combinationally.
  - deq_valid = !empty.
  - Enqueue-to-visible latency is 1 cycle (empty drops the cycle after the write edge).
- FIFO_TYPE 1 (registered read):
  - On an accepted dequeue, mem[rd_ptr] is loaded into the output register and deq_valid is set to 1 in the next cycle.
  - In any cycle with no accepted dequeue, deq_valid is 0 next cycle and deq_data holds its last value.
  - Read latency is 1 cycle after deq_en.
  - count counts only the array; the output register is not included.
- Error flags:
  - overflow is set on enq_en && full; underflow is set on deq_en && empty.
  - Each flag stays set until clear_err or rst.
  - If clear_err coincides with a new error event, the flag ends up set (set wins).
  - A rejected operation has no other side effect: the data is dropped and pointers are unchanged.
- Reset:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1 (AE_THRESH >= 0), almost_full = 0.
  - deq_valid = 0, overflow = 0, underflow = 0.
  - In type 1, deq_data = 0. In type 0, deq_data is don't-care while empty.
  - Reset mid-operation discards all stored entries.
  - Requests in the reset cycle are ignored and do not set error flags.
- The memory array itself is not reset.

Test Plan:
1. WIDTH=8, DEPTH=3, FIFO_TYPE=0. Enqueue 0x11, 0x22, 0x33 on consecutive cycles -> count 1,2,3; full=1 after the third edge; deq_data=0x11 with deq_valid=1 from the cycle after the first enqueue. Then three dequeues -> 0x22, 0x33, then empty=1; pointers wrap 2->0 with no gap.
2. DEPTH=3, full. Assert enq_en=1 (0x44) and deq_en=1 in the same cycle -> the dequeue of 0x11 is accepted, 0x44 is dropped, count=2, overflow=1. clear_err in a later cycle -> overflow=0.
3. FIFO_TYPE=1, DEPTH=4. Enqueue 0xA5, then pulse deq_en -> deq_valid=1 with deq_data=0xA5 exactly one cycle later, deq_valid=0 the following cycle, deq_data holds 0xA5.
4. Empty FIFO. Assert deq_en and enq_en(0x5A) in the same cycle -> underflow=1, count=1, deq_data=0x5A (type 0) next cycle.
5. DEPTH=5, AF_THRESH=4, AE_THRESH=1. Fill 0->5 -> almost_empty=1 at counts 0 and 1, almost_full=1 at counts 4 and 5, full only at 5.
6. With count=3 and overflow=1, assert rst for one cycle while enq_en=1 -> next cycle count=0, empty=1, overflow=0, deq_valid=0, no entry written.
